ones_count: RTL and testbench
=============================

Name: ones_count

Overview:
Population-count block that counts the '1' bits in a WIDTH-bit input word and returns the count as an unsigned binary number. The default configuration is a 7-bit input with a 3-bit count. The combinational popcount is registered once, so a result appears one clock after its input is sampled. Used wherever a bit-vector occupancy or weight is needed.

Parameters:
WIDTH, 7, input vector width in bits (>=1)
COUNT_W, $clog2(WIDTH+1), count width; 3 at the default, wide enough for a value of WIDTH

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  in_data is valid this cycle
in_data  input  WIDTH  vector to be counted
out_valid  output  1  count/flags hold a fresh result
count  output  COUNT_W  number of '1' bits in the sampled in_data
all_zero  output  1  sampled in_data was all zeros (count==0)
all_ones  output  1  sampled in_data was all ones (count==WIDTH)

Behaviour:
- Clocking: one clock, clk. Reset is asynchronous and active-low.
- Reset (rst_n=0, asynchronous assert): out_valid=0, count=0, all_zero=1, all_ones=0. Release is synchronous to clk.
- Each rising edge with in_valid=1:
  - count <= popcount(in_data);
  - all_zero <= (in_data == 0);
  - all_ones <= (in_data == all ones);
  - out_valid <= 1.
- Each rising edge with in_valid=0: out_valid <= 0; count and the flags hold their last value.
- Latency is exactly 1 cycle. Throughput is 1 result per cycle. There is no backpressure and no ready signal.
- The popcount is a pure combinational adder tree of unsigned, zero-extended partial sums. It never overflows COUNT_W, and the maximum value is WIDTH (7 = 3'b111 at the default).
- in_data bits with X/Z are not supported. The bench drives known values only.
- Reset asserted mid-stream: the in-flight result is discarded and the outputs go to their reset values immediately.
- WIDTH=1: count = in_data, COUNT_W = 1.

Decomposition:
- Package ones_count_pkg holds:
  - the function count_width(w) = $clog2(w+1);
  - a typedef for the default 3-bit count.
- Sub-module ones_popcount_tree is combinational and parameterized by WIDTH. It builds a recursive or iterative adder tree: pairs of bits go into half-adders, then partial sums are added level by level. It outputs a COUNT_W-bit sum.
- ones_count instantiates the tree, derives the flags, and holds the output register stage.

Test Plan:
- Reset: hold rst_n=0 with random in_data -> out_valid=0, count=0, all_zero=1, all_ones=0. Reassert rst_n mid-stream -> outputs clear with no clk edge.
- Default vectors, in_valid=1, one per cycle, results checked one cycle later:
  - 0000000 -> 0 (all_zero=1)
  - 1010011 -> 4
  - 0111101 -> 5
  - 1111111 -> 7 (all_ones=1)
  - 0000111 -> 3
  - 0010000 -> 1
  - 1011111 -> 6
  - 0110011 -> 4
- Single-bit walk: one-hot input at each of positions 0..6 -> count=1 every time, all_zero=0, all_ones=0.
- Hold behaviour: apply 1011111 with in_valid=1, then in_valid=0 with in_data=0000000 -> count stays 6, out_valid goes 1 then 0.
- Back-to-back throughput: 100 random vectors on consecutive cycles -> each count equals a reference popcount, with exactly 1-cycle latency.
- Parameter sweep: WIDTH=1, 8, 16 -> COUNT_W is 1, 4, 5; an all-ones input gives 1, 8, 16 with no overflow.

Source files
------------

// File: rtl/ones_count_pkg.sv
// ones_count_pkg: shared definitions for the ones_count population-count block.
//   count_width(w) : bits needed to hold any value 0..w
//   count_t        : count type for the default 7-bit configuration
package ones_count_pkg;

  localparam int unsigned DefaultWidth = 7;

  function automatic int unsigned count_width(input int unsigned w);
    return unsigned'($clog2(w + 1));
  endfunction

  typedef logic [count_width(DefaultWidth)-1:0] count_t;

endpackage

// File: rtl/ones_popcount_tree.sv
// ones_popcount_tree: combinational adder tree returning the number of set bits in i_data.
//   i_data : WIDTH-bit vector to count
//   o_sum  : COUNT_W-bit unsigned population count (max value WIDTH)
module ones_popcount_tree
  import ones_count_pkg::*;
#(
  parameter int unsigned WIDTH   = DefaultWidth,
  parameter int unsigned COUNT_W = count_width(WIDTH)
) (
  input  logic [WIDTH-1:0]   i_data,
  output logic [COUNT_W-1:0] o_sum
);

  localparam int unsigned Levels = unsigned'($clog2(WIDTH));

  // Each level halves the number of live partial sums. Slots past the live range stay zero,
  // so an odd leftover is simply added to zero. The first level is the half-adder stage.
  logic [COUNT_W-1:0] w_sum [Levels+1][2*WIDTH];

  always_comb begin
    for (int unsigned l = 0; l <= Levels; l++) begin
      for (int unsigned i = 0; i < 2 * WIDTH; i++) begin
        w_sum[l][i] = '0;
      end
    end
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_sum[0][i] = COUNT_W'(i_data[i]);
    end
    for (int unsigned l = 1; l <= Levels; l++) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        w_sum[l][i] = w_sum[l-1][2*i] + w_sum[l-1][2*i+1];
      end
    end
  end

  // Partial sums never exceed WIDTH, so COUNT_W bits cannot overflow.
  assign o_sum = w_sum[Levels][0];

endmodule

// File: rtl/ones_count.sv
// ones_count: registered population count of a WIDTH-bit word, one-cycle latency.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : in_data is valid this cycle
//   in_data   : vector to be counted
//   out_valid : count/flags hold a fresh result
//   count     : number of '1' bits in the sampled in_data
//   all_zero  : sampled in_data was all zeros
//   all_ones  : sampled in_data was all ones
module ones_count
  import ones_count_pkg::*;
#(
  parameter int unsigned WIDTH   = DefaultWidth,
  parameter int unsigned COUNT_W = count_width(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  output logic [COUNT_W-1:0] count,
  output logic               all_zero,
  output logic               all_ones
);

  logic [COUNT_W-1:0] w_popcount;

  logic               r_valid;
  logic [COUNT_W-1:0] r_count;
  logic               r_all_zero;
  logic               r_all_ones;

  ones_popcount_tree #(
    .WIDTH   (WIDTH),
    .COUNT_W (COUNT_W)
  ) u_tree (
    .i_data (in_data),
    .o_sum  (w_popcount)
  );

  // Result fields only load on a valid input; otherwise they hold the last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_count    <= '0;
      r_all_zero <= 1'b1;
      r_all_ones <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_count    <= w_popcount;
        r_all_zero <= (in_data == '0);
        r_all_ones <= (in_data == '1);
      end
    end
  end

  assign out_valid = r_valid;
  assign count     = r_count;
  assign all_zero  = r_all_zero;
  assign all_ones  = r_all_ones;

endmodule

// File: tb/tb_ones_count.sv
module tb_ones_count;

  typedef struct {
    int cyc;
    int cnt;
    bit az;
    bit ao;
  } exp_t;

  typedef struct {
    logic [6:0] data;
    int         cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [6:0] in_data = '0;
  logic       out_valid;
  logic [2:0] count;
  logic       all_zero;
  logic       all_ones;

  logic        sw_valid = 1'b0;
  logic [0:0]  d1 = '0;
  logic [7:0]  d8 = '0;
  logic [15:0] d16 = '0;
  logic        v1, v8, v16;
  logic [0:0]  c1;
  logic [3:0]  c8;
  logic [4:0]  c16;
  logic        z1, z8, z16, o1, o8, o16;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q[$];
  exp_t last;

  always #5 clk = ~clk;

  ones_count u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .count     (count),
    .all_zero  (all_zero),
    .all_ones  (all_ones)
  );

  ones_count #(.WIDTH(1)) u_w1 (
    .clk (clk), .rst_n (rst_n), .in_valid (sw_valid), .in_data (d1),
    .out_valid (v1), .count (c1), .all_zero (z1), .all_ones (o1)
  );

  ones_count #(.WIDTH(8)) u_w8 (
    .clk (clk), .rst_n (rst_n), .in_valid (sw_valid), .in_data (d8),
    .out_valid (v8), .count (c8), .all_zero (z8), .all_ones (o8)
  );

  ones_count #(.WIDTH(16)) u_w16 (
    .clk (clk), .rst_n (rst_n), .in_valid (sw_valid), .in_data (d16),
    .out_valid (v16), .count (c16), .all_zero (z16), .all_ones (o16)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int ref_pop(input logic [6:0] d);
    int n = 0;
    for (int i = 0; i < 7; i++) if (d[i]) n++;
    return n;
  endfunction

  task automatic set_last_reset();
    last = '{cyc: 0, cnt: 0, az: 1'b1, ao: 1'b0};
  endtask

  task automatic drive(input logic v, input logic [6:0] d, input int cnt);
    @(posedge clk);
    #1;
    in_valid = v;
    in_data  = d;
    if (v) exp_q.push_back('{cyc: cyc + 1, cnt: cnt, az: (cnt == 0), ao: (cnt == 7)});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_all_zero"}, int'(all_zero), 1);
    chk({tag, "_all_ones"}, int'(all_ones), 0);
  endtask

  // Monitor: a result must appear exactly in the cycle the scoreboard expects it;
  // in every other cycle out_valid is low and the last result is held.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_valid", int'(out_valid), 1);
        chk("count", int'(count), e.cnt);
        chk("all_zero", int'(all_zero), int'(e.az));
        chk("all_ones", int'(all_ones), int'(e.ao));
        last = e;
      end else begin
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          chk("missed_result_cycle", cyc, exp_q[0].cyc);
          void'(exp_q.pop_front());
        end
        chk("idle_out_valid", int'(out_valid), 0);
        chk("hold_count", int'(count), last.cnt);
        chk("hold_all_zero", int'(all_zero), int'(last.az));
        chk("hold_all_ones", int'(all_ones), int'(last.ao));
      end
    end
  end

  vec_t vecs[8] = '{
    '{7'b0000000, 0}, '{7'b1010011, 4}, '{7'b0111101, 5}, '{7'b1111111, 7},
    '{7'b0000111, 3}, '{7'b0010000, 1}, '{7'b1011111, 6}, '{7'b0110011, 4}
  };

  initial begin
    set_last_reset();
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    // Reset held while valid random data is presented.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = 7'($urandom);
      @(posedge clk);
      #1 chk_reset_outputs("reset_hold");
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    foreach (vecs[i]) drive(1'b1, vecs[i].data, vecs[i].cnt);
    drive(1'b0, 7'b0, 0);

    for (int i = 0; i < 7; i++) begin
      logic [6:0] oh;
      oh = 7'b1 << i;
      drive(1'b1, oh, 1);
    end
    drive(1'b0, 7'b0, 0);

    // Hold: count 6 must survive an invalid cycle carrying zero data.
    drive(1'b1, 7'b1011111, 6);
    drive(1'b0, 7'b0000000, 0);
    drive(1'b0, 7'b0000000, 0);

    for (int i = 0; i < 100; i++) begin
      logic [6:0] r;
      r = 7'($urandom);
      drive(1'b1, r, ref_pop(r));
    end
    drive(1'b0, 7'b0, 0);
    drive(1'b0, 7'b0, 0);

    // Mid-stream reset: the in-flight result is discarded without a clock edge.
    drive(1'b1, 7'b1111111, 7);
    drive(1'b1, 7'b0000111, 3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    set_last_reset();
    #1 chk_reset_outputs("midstream_reset");
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b0, 7'b0, 0);
    drive(1'b1, 7'b0010011, 3);
    drive(1'b0, 7'b0, 0);
    drive(1'b0, 7'b0, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    mon_en = 1'b0;

    // Parameter sweep.
    @(posedge clk);
    #1;
    sw_valid = 1'b1;
    d1 = 1'b1;
    d8 = 8'hFF;
    d16 = 16'hFFFF;
    @(posedge clk);
    #1;
    chk("w1_valid", int'(v1), 1);
    chk("w1_count", int'(c1), 1);
    chk("w1_all_ones", int'(o1), 1);
    chk("w8_count", int'(c8), 8);
    chk("w8_all_ones", int'(o8), 1);
    chk("w16_count", int'(c16), 16);
    chk("w16_all_ones", int'(o16), 1);
    d1 = 1'b0;
    d8 = 8'h81;
    d16 = 16'h8001;
    @(posedge clk);
    #1;
    chk("w1_zero_count", int'(c1), 0);
    chk("w1_all_zero", int'(z1), 1);
    chk("w8_sparse_count", int'(c8), 2);
    chk("w8_sparse_all_zero", int'(z8), 0);
    chk("w16_sparse_count", int'(c16), 2);
    chk("w16_sparse_all_ones", int'(o16), 0);
    sw_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("w16_valid_drop", int'(v16), 0);
    chk("w16_hold_count", int'(c16), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
